rom_scan_ctrl: RTL and testbench

Sequencer that owns the puzzle-input ROM and its accumulate datapath. On a `start` pulse it walks the ROM addresses `0..count-1` and tracks each read through a latency-matched valid pipeline. It sums every returned word into a registered score, then reports completion with a one-cycle `done` pulse. It replaces the free-running counter-plus-fixed-bound scheme and sits between the top-level run control and `rom_hardcoded`.

---
 rtl/rom_scan_pkg.sv | 18 +
 rtl/scan_valid_pipe.sv | 37 +++
 rtl/rom_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_rom_scan_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rom_scan_pkg.sv
// Shared types and default sizes for the ROM scan controller.
// Holds the scan FSM state type, the default widths and the largest
// supported extra ROM read latency.
package rom_scan_pkg;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 32;
    localparam int ACC_W       = 32;
    localparam int ROM_LAT_MAX = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/scan_valid_pipe.sv
// Valid-tag shift register that tracks ROM reads through the ROM latency.
// A 1 pushed in emerges on tag_out DEPTH edges later; in_flight is high
// while any stage still holds a tag.
module scan_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic tag_in,
    output logic tag_out,
    output logic in_flight
);

    logic [DEPTH-1:0] stage_reg;
    logic [DEPTH-1:0] stage_next;

    // Stage 0 takes the new tag, every later stage takes its predecessor.
    assign stage_next[0] = tag_in;
    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
            assign stage_next[gi] = stage_reg[gi-1];
        end
    endgenerate

    // Advance the tags one stage per clock; reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    assign tag_out   = stage_reg[DEPTH-1];
    assign in_flight = |stage_reg;

endmodule

// File: rtl/rom_scan_ctrl.sv
// ROM scan sequencer: on start, reads ROM addresses 0..count-1 at one word
// per cycle, sums the returned words into score and pulses done once the
// last add has landed.
// Optional build macro ROM_SCAN_SAT_EN: score saturates to all-ones on a
// carry out instead of wrapping (overflow is flagged either way).
module rom_scan_ctrl
    import rom_scan_pkg::*;
#(
    parameter int ADDR_W  = rom_scan_pkg::ADDR_W,
    parameter int DATA_W  = rom_scan_pkg::DATA_W,
    parameter int ACC_W   = rom_scan_pkg::ACC_W,
    parameter int ROM_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  score,
    output logic              overflow
);

    // Latency outside the supported range is pinned to the maximum.
    localparam int LAT = (ROM_LAT > ROM_LAT_MAX) ? ROM_LAT_MAX : ROM_LAT;

    scan_state_t       state_reg;
    logic [ADDR_W-1:0] fetch_idx_reg;
    logic [ADDR_W-1:0] last_idx_reg;
    logic [ADDR_W-1:0] last_idx_next;
    logic              start_accept;
    logic              fetch_push;
    logic              tag_out;
    logic              pipe_busy;
    logic [DATA_W-1:0] data_reg;
    logic              data_valid_reg;
    logic [ACC_W:0]    sum_wide;

    assign start_accept = (state_reg == ST_IDLE) && start;
    assign fetch_push   = (state_reg == ST_FETCH);

    // Any count of 2^ADDR_W or more scans the full ROM, so the last address
    // is all-ones; otherwise it is count-1 (unused when count is 0).
    assign last_idx_next = count[ADDR_W] ? '1 : (count[ADDR_W-1:0] - 1'b1);

    scan_valid_pipe #(
        .DEPTH (LAT + 1)
    ) u_valid_pipe (
        .clk       (clk),
        .rst       (rst),
        .tag_in    (fetch_push),
        .tag_out   (tag_out),
        .in_flight (pipe_busy)
    );

    // Scan FSM with registered address, busy and done outputs.
    // An empty run goes through DRAIN: the pipe is already empty, so it
    // reaches DONE one edge later with nothing ever read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            fetch_idx_reg <= '0;
            last_idx_reg  <= '0;
            rom_addr      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy          <= 1'b1;
                        fetch_idx_reg <= '0;
                        last_idx_reg  <= last_idx_next;
                        rom_addr      <= '0;
                        state_reg     <= (count == '0) ? ST_DRAIN : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // Address k goes out on this edge while its tag enters the pipe.
                    rom_addr      <= fetch_idx_reg;
                    fetch_idx_reg <= fetch_idx_reg + 1'b1;
                    if (fetch_idx_reg == last_idx_reg) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Once the pipe is empty the capture stage holds the last
                    // word, so the final add lands on the same edge as done.
                    if (!pipe_busy) begin
                        state_reg <= ST_DONE;
                        done      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign sum_wide = {1'b0, score} + {{(ACC_W + 1 - DATA_W){1'b0}}, data_reg};

    // Capture stage and accumulator; the score is cleared by an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg       <= '0;
            data_valid_reg <= 1'b0;
            score          <= '0;
            overflow       <= 1'b0;
        end else if (start_accept) begin
            data_valid_reg <= 1'b0;
            score          <= '0;
            overflow       <= 1'b0;
        end else begin
            data_valid_reg <= tag_out;
            if (tag_out) begin
                data_reg <= rom_data;
            end
            if (data_valid_reg) begin
                overflow <= overflow | sum_wide[ACC_W];
`ifdef ROM_SCAN_SAT_EN
                score <= sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
`else
                score <= sum_wide[ACC_W-1:0];
`endif
            end
        end
    end

endmodule

// File: tb/tb_rom_scan_ctrl.sv
// Directed bench for rom_scan_ctrl: one instance with a combinational ROM
// and one with two registered ROM stages, both fed from a bench memory.
module tb_rom_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic [8:0]  count0, count1;
    logic [7:0]  rom_addr0, rom_addr1;
    logic [31:0] rom_data0, rom_data1;
    logic        busy0, busy1, done0, done1, overflow0, overflow1;
    logic [31:0] score0, score1;

    logic [31:0] mem [256];
    logic [31:0] lat_a, lat_b;

    int total = 0;
    int bad   = 0;

`ifdef ROM_SCAN_SAT_EN
    localparam logic [31:0] OVF_SCORE = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] OVF_SCORE = 32'h0000_0001;
`endif

    always #5 clk = ~clk;

    always_comb rom_data0 = mem[rom_addr0];

    always @(posedge clk) begin
        lat_a <= mem[rom_addr1];
        lat_b <= lat_a;
    end
    assign rom_data1 = lat_b;

    rom_scan_ctrl #(.ADDR_W(8), .DATA_W(32), .ACC_W(32), .ROM_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .count(count0),
        .rom_addr(rom_addr0), .rom_data(rom_data0), .busy(busy0),
        .done(done0), .score(score0), .overflow(overflow0)
    );

    rom_scan_ctrl #(.ADDR_W(8), .DATA_W(32), .ACC_W(32), .ROM_LAT(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .count(count1),
        .rom_addr(rom_addr1), .rom_data(rom_data1), .busy(busy1),
        .done(done1), .score(score1), .overflow(overflow1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d (0x%0h) want=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic put_start(input bit sel, input logic v, input logic [8:0] cnt);
        if (sel) begin
            start1 = v;
            count1 = cnt;
        end else begin
            start0 = v;
            count0 = cnt;
        end
    endtask

    // One scan; edges are numbered from the edge that accepts start (edge 0).
    // With poke set, start is also raised during FETCH and during DONE.
    task automatic run(input bit sel, input int n, input bit poke,
                       input logic [31:0] exp_score, input bit exp_ovf,
                       input int exp_done, input int exp_fall, input int exp_maxa,
                       input string name);
        int          e, done_e, fall_e, nd, maxa;
        logic [31:0] sc;
        logic        ov;
        logic [7:0]  a;
        e = 0; done_e = -1; fall_e = -1; nd = 0; maxa = 0; sc = '0; ov = 1'b0;
        @(negedge clk);
        put_start(sel, 1'b1, 9'(n));
        @(negedge clk);
        put_start(sel, 1'b0, 9'(n));
        chk({name, "_busy_rise"}, sel ? busy1 : busy0, 1);
        for (int c = 0; c < 600 && fall_e < 0; c++) begin
            @(negedge clk);
            e++;
            put_start(sel, 1'b0, 9'(n));
            if (poke && e == 2) put_start(sel, 1'b1, 9'd1);
            if (sel ? done1 : done0) begin
                nd++;
                if (nd == 1) begin
                    done_e = e;
                    sc = sel ? score1 : score0;
                    ov = sel ? overflow1 : overflow0;
                end
                if (poke) put_start(sel, 1'b1, 9'd1);
            end
            a = sel ? rom_addr1 : rom_addr0;
            if (int'(a) > maxa) maxa = int'(a);
            if (!(sel ? busy1 : busy0)) fall_e = e;
        end
        put_start(sel, 1'b0, 9'(n));
        chk({name, "_done_edge"}, done_e, exp_done);
        chk({name, "_busy_fall"}, fall_e, exp_fall);
        chk({name, "_done_pulses"}, nd, 1);
        chk({name, "_score"}, sc, exp_score);
        chk({name, "_overflow"}, ov, exp_ovf);
        chk({name, "_max_addr"}, maxa, exp_maxa);
        $display("run %s: n=%0d score=0x%0h ovf=%0d done_edge=%0d busy_fall=%0d max_addr=%0d",
                 name, n, sc, ov, done_e, fall_e, maxa);
    endtask

    initial begin
        int  nd;
        bit  hit;
        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0; count0 = '0; count1 = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'(i + 1);

        repeat (3) @(negedge clk);
        chk("reset_addr", rom_addr0, 0);
        chk("reset_busy", busy0, 0);
        chk("reset_done", done0, 0);
        chk("reset_score", score0, 0);
        chk("reset_ovf", overflow0, 0);
        $display("reset: addr=%0d busy=%0d done=%0d score=%0d ovf=%0d",
                 rom_addr0, busy0, done0, score0, overflow0);
        rst = 1'b0;

        // Words 1,2,3,4 -> 10, done after edge 6, busy falls after edge 7.
        run(1'b0, 4, 1'b0, 32'd10, 1'b0, 6, 7, 3, "lat0_n4");
        // Empty run: done after edge 1, nothing beyond address 0.
        run(1'b0, 0, 1'b0, 32'd0, 1'b0, 1, 2, 0, "n0");
        // 1+2+...+201 = 201*202/2 = 20301, done after edge 201+2+2.
        run(1'b1, 201, 1'b0, 32'd20301, 1'b0, 205, 206, 200, "lat2_n201");

        // Reset in the middle of a long fetch.
        @(negedge clk);
        put_start(1'b0, 1'b1, 9'd200);
        @(negedge clk);
        put_start(1'b0, 1'b0, 9'd200);
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            if (rom_addr0 == 8'd50) hit = 1'b1;
        end
        chk("rst_reach_addr50", hit, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_addr", rom_addr0, 0);
        chk("rst_mid_busy", busy0, 0);
        chk("rst_mid_done", done0, 0);
        chk("rst_mid_score", score0, 0);
        chk("rst_mid_ovf", overflow0, 0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done0 || busy0) nd++;
        end
        chk("rst_no_done", nd, 0);
        $display("mid-run reset: addr=%0d busy=%0d score=%0d", rom_addr0, busy0, score0);

        // 1+2+3 = 6, done after edge 5.
        run(1'b0, 3, 1'b0, 32'd6, 1'b0, 5, 6, 2, "after_rst_n3");

        // Stray starts in FETCH and DONE are ignored.
        run(1'b0, 4, 1'b1, 32'd10, 1'b0, 6, 7, 3, "ignore_start");
        repeat (3) @(negedge clk);
        chk("ignore_idle_busy", busy0, 0);
        chk("ignore_score_held", score0, 10);
        $display("after ignored starts: busy=%0d score=%0d", busy0, score0);
        run(1'b0, 3, 1'b0, 32'd6, 1'b0, 5, 6, 2, "restart_n3");

        // FFFF_FFFF + 2 carries out of 32 bits.
        mem[0] = 32'hFFFF_FFFF;
        mem[1] = 32'd2;
        run(1'b0, 2, 1'b0, OVF_SCORE, 1'b1, 4, 5, 1, "overflow");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
